// File: rtl/zilla_data_mem_if.sv
// Request/response bundle on the zilla_32 data-memory port.
// The core side is the master modport; zilla_data_mem is the slave.
interface zilla_data_mem_if #(
  parameter int D_WIDTH = 32
) ();
  logic                    data_mem_write_en_i;
  logic [D_WIDTH-1:0]      data_mem_write_addr_i;
  logic [D_WIDTH-1:0]      data_mem_write_data_i;
  logic [(D_WIDTH>>3)-1:0] data_mem_strobe_i;
  logic                    data_mem_read_en_i;
  logic [D_WIDTH-1:0]      data_mem_read_addr_i;
  logic [D_WIDTH-1:0]      data_mem_read_data_o;
  logic                    data_mem_read_valid_o;
  logic                    data_mem_err_o;

  modport master (
    output data_mem_write_en_i,
    output data_mem_write_addr_i,
    output data_mem_write_data_i,
    output data_mem_strobe_i,
    output data_mem_read_en_i,
    output data_mem_read_addr_i,
    input  data_mem_read_data_o,
    input  data_mem_read_valid_o,
    input  data_mem_err_o
  );

  modport slave (
    input  data_mem_write_en_i,
    input  data_mem_write_addr_i,
    input  data_mem_write_data_i,
    input  data_mem_strobe_i,
    input  data_mem_read_en_i,
    input  data_mem_read_addr_i,
    output data_mem_read_data_o,
    output data_mem_read_valid_o,
    output data_mem_err_o
  );
endinterface

// File: rtl/zilla_data_mem.sv
// Byte-strobed synchronous data memory for zilla_32: write-first, fixed RD_LAT
// read pipeline, and a one-cycle error pulse for out-of-range accesses.
module zilla_data_mem #(
  parameter int                 D_WIDTH     = 32,
  parameter int                 DEPTH_WORDS = 1024,
  parameter logic [D_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                 RD_LAT      = 1
) (
  input  logic             mem_clk,
  input  logic             mem_rst_n,
  zilla_data_mem_if.slave  bus
);

  localparam int STRB_W  = D_WIDTH >> 3;
  localparam int IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LANE_SH = $clog2(STRB_W);
  // One extra bit so a window ending exactly at 2**D_WIDTH is representable.
  localparam logic [D_WIDTH:0] SPAN = (D_WIDTH+1)'(DEPTH_WORDS) << LANE_SH;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("zilla_data_mem: RD_LAT must be in 1..4");
  end
  if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("zilla_data_mem: DEPTH_WORDS must be a power of two");
  end

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } decode_t;

  // Offset from BASE_ADDR is only meaningful when addr >= BASE_ADDR, so the
  // lower-bound test guards the subtraction against wrap-around.
  function automatic decode_t decode(input logic [D_WIDTH-1:0] addr);
    decode_t             d;
    logic [D_WIDTH-1:0]  off;
    off   = addr - BASE_ADDR;
    d.hit = (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    d.idx = off[LANE_SH +: IDX_W];
    return d;
  endfunction

  decode_t wr_dec;
  decode_t rd_dec;
  logic    wr_hit;
  logic    rd_req;
  logic    acc_err;

  assign wr_dec  = decode(bus.data_mem_write_addr_i);
  assign rd_dec  = decode(bus.data_mem_read_addr_i);
  assign wr_hit  = bus.data_mem_write_en_i && wr_dec.hit;
  assign rd_req  = bus.data_mem_read_en_i;
  assign acc_err = (bus.data_mem_write_en_i && !wr_dec.hit) ||
                   (bus.data_mem_read_en_i  && !rd_dec.hit);

  logic [D_WIDTH-1:0] mem [DEPTH_WORDS];

  // NOTE: the storage array deliberately has no reset branch; clearing it
  // would force a flop-based array instead of a RAM, and contents must
  // survive reset anyway. Gating on mem_rst_n drops writes during reset.
  always_ff @(posedge mem_clk) begin
    if (mem_rst_n && wr_hit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.data_mem_strobe_i[b]) begin
          mem[wr_dec.idx][8*b +: 8] <= bus.data_mem_write_data_i[8*b +: 8];
        end
      end
    end
  end

  // Stage-1 capture value: write-first merge for a same-cycle write to the
  // same word, zero for out-of-range reads.
  logic [D_WIDTH-1:0] rd_word;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_word = '0;
    if (rd_dec.hit) begin
      rd_word = mem[rd_dec.idx];
      if (wr_hit && (wr_dec.idx == rd_dec.idx)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (bus.data_mem_strobe_i[b]) begin
            rd_word[8*b +: 8] = bus.data_mem_write_data_i[8*b +: 8];
          end
        end
      end
    end
  end

  logic [RD_LAT:1]    pipe_vld;
  logic [D_WIDTH-1:0] pipe_data [1:RD_LAT];
  logic               err_q;

  // Data registers only load behind a valid bit, so the last stage keeps its
  // most recent result while no read is completing.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its predecessor.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      pipe_vld <= '0;
      for (int k = 1; k <= RD_LAT; k++) begin
        pipe_data[k] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      pipe_vld[1] <= rd_req;
      if (rd_req) begin
        pipe_data[1] <= rd_word;
      end
      for (int k = 2; k <= RD_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) begin
          pipe_data[k] <= pipe_data[k-1];
        end
      end
      err_q <= acc_err;
    end
  end

  assign bus.data_mem_read_data_o  = pipe_data[RD_LAT];
  assign bus.data_mem_read_valid_o = pipe_vld[RD_LAT];
  assign bus.data_mem_err_o        = err_q;

endmodule

// File: tb/tb_zilla_data_mem.sv
// Directed bench for zilla_data_mem: three instances (RD_LAT 1, 3, 4) share
// one stimulus stream and are checked against hand-computed values.
module tb_zilla_data_mem;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic        re;
  logic [31:0] raddr;

  int n_tests = 0;
  int n_fail  = 0;

  zilla_data_mem_if #(.D_WIDTH(32)) if1 ();
  zilla_data_mem_if #(.D_WIDTH(32)) if3 ();
  zilla_data_mem_if #(.D_WIDTH(32)) if4 ();

  assign if1.data_mem_write_en_i   = we;
  assign if1.data_mem_write_addr_i = waddr;
  assign if1.data_mem_write_data_i = wdata;
  assign if1.data_mem_strobe_i     = strb;
  assign if1.data_mem_read_en_i    = re;
  assign if1.data_mem_read_addr_i  = raddr;

  assign if3.data_mem_write_en_i   = we;
  assign if3.data_mem_write_addr_i = waddr;
  assign if3.data_mem_write_data_i = wdata;
  assign if3.data_mem_strobe_i     = strb;
  assign if3.data_mem_read_en_i    = re;
  assign if3.data_mem_read_addr_i  = raddr;

  assign if4.data_mem_write_en_i   = we;
  assign if4.data_mem_write_addr_i = waddr;
  assign if4.data_mem_write_data_i = wdata;
  assign if4.data_mem_strobe_i     = strb;
  assign if4.data_mem_read_en_i    = re;
  assign if4.data_mem_read_addr_i  = raddr;

  zilla_data_mem #(.RD_LAT(1)) u_dut1 (.mem_clk(clk), .mem_rst_n(rst_n), .bus(if1.slave));
  zilla_data_mem #(.RD_LAT(3)) u_dut3 (.mem_clk(clk), .mem_rst_n(rst_n), .bus(if3.slave));
  zilla_data_mem #(.RD_LAT(4)) u_dut4 (.mem_clk(clk), .mem_rst_n(rst_n), .bus(if4.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] s, input logic r, input logic [31:0] ra);
    we = w; waddr = wa; wdata = wd; strb = s; re = r; raddr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(1'b1, a, d, s, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    check("rst_data1",  if1.data_mem_read_data_o,  32'h0);
    check("rst_valid1", if1.data_mem_read_valid_o, 32'h0);
    check("rst_valid4", if4.data_mem_read_valid_o, 32'h0);
    check("rst_err1",   if1.data_mem_err_o,        32'h0);
    #2 rst_n = 1'b1;

    // Preload words used below.
    wr(32'h0,   32'h0,         4'hF);
    wr(32'h4,   32'h4,         4'hF);
    wr(32'h8,   32'h8,         4'hF);
    wr(32'hC,   32'hC,         4'hF);
    wr(32'h20,  32'h0,         4'hF);
    wr(32'hFFC, 32'hCAFE_0FFC, 4'hF);
    idle();
    check("pre_valid1", if1.data_mem_read_valid_o, 32'h0);

    // Read word 0 at BASE_ADDR.
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    tick();
    check("rd0_valid1", if1.data_mem_read_valid_o, 32'h1);
    check("rd0_data1",  if1.data_mem_read_data_o,  32'h0);
    check("rd0_err1",   if1.data_mem_err_o,        32'h0);
    idle();
    tick();
    check("rd0_pulse1", if1.data_mem_read_valid_o, 32'h0);
    check("rd0_err1b",  if1.data_mem_err_o,        32'h0);

    // Byte-strobed overwrite, unaligned read address.
    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    wr(32'h10, 32'h1122_3344, 4'b0101);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h12);
    tick();
    check("strb_data1",  if1.data_mem_read_data_o,  32'hDE22_BE44);
    check("strb_valid1", if1.data_mem_read_valid_o, 32'h1);
    idle();
    tick();
    check("hold_valid1", if1.data_mem_read_valid_o, 32'h0);
    check("hold_data1",  if1.data_mem_read_data_o,  32'hDE22_BE44);
    check("strb_valid3a", if3.data_mem_read_valid_o, 32'h0);
    tick();
    check("strb_valid3", if3.data_mem_read_valid_o, 32'h1);
    check("strb_data3",  if3.data_mem_read_data_o,  32'hDE22_BE44);
    tick();
    check("strb_valid4", if4.data_mem_read_valid_o, 32'h1);
    check("strb_data4",  if4.data_mem_read_data_o,  32'hDE22_BE44);

    // Same-cycle write and read to one word: write-first with lane merge.
    drive(1'b1, 32'h20, 32'hA5A5_A5A5, 4'b0011, 1'b1, 32'h20);
    tick();
    check("wf_data1",  if1.data_mem_read_data_o,  32'h0000_A5A5);
    check("wf_valid1", if1.data_mem_read_valid_o, 32'h1);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20);
    tick();
    check("wf_persist1", if1.data_mem_read_data_o, 32'h0000_A5A5);
    idle();
    tick();
    tick();
    tick();

    // Back-to-back reads of 0x0, 0x4, 0x8, 0xC.
    for (int j = 0; j < 7; j++) begin
      if (j < 4) drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'(4 * j));
      else       idle();
      tick();
      if (j < 4) check($sformatf("b2b_data1_%0d", j), if1.data_mem_read_data_o, 32'(4 * j));
      check($sformatf("b2b_valid3_%0d", j), if3.data_mem_read_valid_o,
            32'((j >= 2 && j <= 5) ? 1 : 0));
      if (j >= 2 && j <= 5)
        check($sformatf("b2b_data3_%0d", j), if3.data_mem_read_data_o, 32'(4 * (j - 2)));
      check($sformatf("b2b_valid4_%0d", j), if4.data_mem_read_valid_o,
            32'((j >= 3) ? 1 : 0));
      if (j >= 3)
        check($sformatf("b2b_data4_%0d", j), if4.data_mem_read_data_o, 32'(4 * (j - 3)));
    end
    idle();
    tick();
    check("b2b_end4", if4.data_mem_read_valid_o, 32'h0);

    // Write lands while the read sits in stage 2: no late forwarding.
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    tick();
    drive(1'b1, 32'h0, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
    tick();
    idle();
    tick();
    check("nofwd_valid3", if3.data_mem_read_valid_o, 32'h1);
    check("nofwd_data3",  if3.data_mem_read_data_o,  32'h0);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    tick();
    check("nofwd_data4", if4.data_mem_read_data_o, 32'h0);
    check("newval_data1", if1.data_mem_read_data_o, 32'h1234_5678);
    idle();
    tick();
    tick();
    tick();
    tick();

    // Out-of-range read, then out-of-range write at the top of the address space.
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000);
    tick();
    check("oor_rd_valid1", if1.data_mem_read_valid_o, 32'h1);
    check("oor_rd_data1",  if1.data_mem_read_data_o,  32'h0);
    check("oor_rd_err1",   if1.data_mem_err_o,        32'h1);
    check("oor_rd_err4",   if4.data_mem_err_o,        32'h1);
    idle();
    tick();
    check("oor_rd_pulse1", if1.data_mem_err_o, 32'h0);
    wr(32'hFFFF_FFFC, 32'h5555_5555, 4'hF);
    idle();
    check("oor_wr_err1", if1.data_mem_err_o, 32'h1);
    check("oor_wr_err3", if3.data_mem_err_o, 32'h1);
    tick();
    check("oor_wr_pulse1", if1.data_mem_err_o, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hFFC);
    tick();
    check("top_data1", if1.data_mem_read_data_o, 32'hCAFE_0FFC);
    check("top_err1",  if1.data_mem_err_o,       32'h0);

    // Both accesses out of range in the same cycle: a single pulse.
    drive(1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h1000);
    tick();
    idle();
    check("both_err1", if1.data_mem_err_o, 32'h1);
    tick();
    check("both_pulse1", if1.data_mem_err_o, 32'h0);
    tick();
    tick();
    tick();

    // Asynchronous reset with reads in flight on the RD_LAT=4 instance.
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h8);
    tick();
    idle();
    check("pre_rst_data1", if1.data_mem_read_data_o, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("async_data1",  if1.data_mem_read_data_o,  32'h0);
    check("async_valid1", if1.data_mem_read_valid_o, 32'h0);
    check("async_valid4", if4.data_mem_read_valid_o, 32'h0);
    drive(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
    tick();
    tick();
    idle();
    #2 rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("flush_valid4_%0d", j), if4.data_mem_read_valid_o, 32'h0);
      check($sformatf("flush_valid3_%0d", j), if3.data_mem_read_valid_o, 32'h0);
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4);
    tick();
    idle();
    check("rst_wr_drop1", if1.data_mem_read_data_o, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
